// File: rtl/serial_shift_unit_pkg.sv
// rtl/serial_shift_unit_pkg.sv - shared constants and types for the serial shift unit
//
// Purpose: operation encodings, FSM state type, default widths and the
// op-validity helper shared by the interface, top and step shifter.
package shift_unit_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  // Codes 101..111 are NOPs; 111 is the value held in the op latch after reset.
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/serial_shift_unit_if.sv
// rtl/serial_shift_unit_if.sv - start/busy/done handshake and data bus of the shift unit
//
// Purpose: bundles the control-FSM request (start, op, shamt, data_in) and the
// unit's status/result (busy, done, data_out).
// Modports:
//   master - control side: drives start/op/shamt/data_in, observes busy/done/data_out
//   slave  - shift unit:   observes the request, drives busy/done/data_out
interface serial_shift_unit_if #(
  parameter int WIDTH   = shift_unit_pkg::DEF_WIDTH,
  parameter int SHAMT_W = shift_unit_pkg::DEF_SHAMT_W
);

  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   data_out;

  modport master (
    output start, op, shamt, data_in,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, shamt, data_in,
    output busy, done, data_out
  );

endinterface

// File: rtl/serial_shift_unit_step.sv
// rtl/serial_shift_unit_step.sv - combinational single-bit shift/rotate step
//
// Purpose: computes one 1-bit step of the selected operation.
// Ports:
//   op_i    - operation code (SLL/SRL/SRA/ROR/ROL, others pass through)
//   value_i - current shift-register value
//   value_o - value after one step
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    case (op_i)
      OP_SLL:  value_o = {value_i[WIDTH-2:0], 1'b0};
      OP_SRL:  value_o = {1'b0, value_i[WIDTH-1:1]};
      OP_SRA:  value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
      OP_ROR:  value_o = {value_i[0], value_i[WIDTH-1:1]};
      OP_ROL:  value_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
      default: value_o = value_i;
    endcase
  end

endmodule

// File: rtl/serial_shift_unit.sv
// rtl/serial_shift_unit.sv - multicycle one-bit-per-clock shift datapath
//
// Purpose: shifts/rotates an operand by N bits, one bit per clock, under a
// start/busy/done handshake. The shift register doubles as data_out and holds
// the result until the next accepted start.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - slave side of serial_shift_unit_if (start/op/shamt/data_in in,
//           busy/done/data_out out)
module serial_shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  serial_shift_unit_if.slave bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [2:0]         op_q,    op_d;
  logic [WIDTH-1:0]   step_value;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op_i    (op_q),
    .value_i (shreg_q),
    .value_o (step_value)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          shreg_d = bus.data_in;
          op_d    = bus.op;
          count_d = bus.shamt;
          // Zero shifts and NOP codes skip SHIFT entirely, so data_out is data_in.
          state_d = ((bus.shamt != '0) && op_is_valid(bus.op)) ? ST_SHIFT : ST_DONE;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // start is ignored here; the running shift is never disturbed.
        shreg_d = step_value;
        count_d = count_q - 1'b1;
        if (count_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      count_q <= '0;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.data_out = shreg_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// tb/tb_serial_shift_unit.sv - directed self-checking bench for serial_shift_unit
module tb_serial_shift_unit;
  import shift_unit_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  serial_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  serial_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: that half-cycle is cycle 0 with start high.
  // poke_cyc > 0 pulses start with unrelated data in that cycle.
  task automatic run(input string tag, input logic [2:0] o, input logic [4:0] n,
                     input logic [31:0] d, input logic [31:0] exp_q,
                     input int exp_cyc, input int exp_busy, input int poke_cyc);
    int cyc;
    int done_cyc;
    int busy_cnt;
    logic [31:0] q_at_done;
    bus.start = 1'b1; bus.op = o; bus.shamt = n; bus.data_in = d;
    cyc = 0; done_cyc = -1; busy_cnt = 0; q_at_done = 'x;
    while (done_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cyc  = cyc;
        q_at_done = bus.data_out;
      end
      if (cyc == poke_cyc) begin
        bus.start = 1'b1; bus.op = OP_SLL; bus.shamt = 5'd2; bus.data_in = 32'h1234_5678;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk({tag, "_done_cycle"}, done_cyc, exp_cyc);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, "_data"}, q_at_done, exp_q);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = OP_SLL; bus.shamt = '0; bus.data_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_data", bus.data_out, 0);
    reset = 1'b1;
    @(negedge clk);

    run("sll4",  OP_SLL, 5'd4,  32'h0000_0001, 32'h0000_0010, 5,  4,  0);
    @(negedge clk);
    chk("sll4_hold_idle", bus.data_out, 32'h0000_0010);
    run("sra31", OP_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32, 31, 0);
    @(negedge clk);
    run("srl31", OP_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001, 32, 31, 0);
    @(negedge clk);
    run("ror1",  OP_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000, 2,  1,  0);
    @(negedge clk);
    run("rol4",  OP_ROL, 5'd4,  32'h8000_00F0, 32'h0000_0F08, 5,  4,  0);
    @(negedge clk);
    run("sra4",  OP_SRA, 5'd4,  32'h8765_4321, 32'hF876_5432, 5,  4,  0);
    @(negedge clk);
    run("sll0",  OP_SLL, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1,  0,  0);
    @(negedge clk);
    run("nop7",  3'b111, 5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1,  0,  0);
    @(negedge clk);
    run("nop5",  3'b101, 5'd9,  32'h1357_9BDF, 32'h1357_9BDF, 1,  0,  0);
    @(negedge clk);
    run("busy_ignore", OP_SRL, 5'd8, 32'hF000_0000, 32'h00F0_0000, 9, 8, 3);
    @(negedge clk);

    // Back-to-back: second start issued in the done cycle of the first.
    run("b2b_first",  OP_SLL, 5'd3, 32'h0000_0003, 32'h0000_0018, 4, 3, 0);
    run("b2b_second", OP_ROR, 5'd2, 32'h0000_0003, 32'hC000_0000, 3, 2, 0);
    @(negedge clk);

    // Reset in cycle 3 of a 10-step shift.
    bus.start = 1'b1; bus.op = OP_SRL; bus.shamt = 5'd10; bus.data_in = 32'hFFFF_0000;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midshift_busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_data", bus.data_out, 0);
    @(negedge clk);
    chk("abort_no_done", bus.done, 0);
    reset = 1'b1;
    @(negedge clk);
    run("post_reset_sll2", OP_SLL, 5'd2, 32'h0000_0001, 32'h0000_0004, 3, 2, 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
